// File: rtl/fpu_mailbox_seq.sv
// rtl/fpu_mailbox_seq.sv - round-robin mailbox sequencer between the shared byte RAM and an external FPU
module fpu_mailbox_seq #(
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_SLOTS   = 4,
    parameter int RD_LAT      = 2,
    parameter int FPU_LATENCY = 4,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  wen,
    output logic [1:0]            fpu_op,
    output logic [31:0]           fpu_a,
    output logic [31:0]           fpu_b,
    output logic                  fpu_start,
    input  logic [31:0]           fpu_s,
    output logic                  busy,
    output logic                  cmd_done,
    output logic [SW-1:0]         cmd_slot
);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_LOAD, S_EXEC, S_WRITE, S_WERR, S_DONE
    } state_t;

    localparam logic [7:0] POLL_LAST = 8'(RD_LAT);
    localparam logic [7:0] CMD_CAP   = 8'(RD_LAT - 1);
    localparam logic [7:0] CAP_LO    = 8'(RD_LAT - 1);
    localparam logic [7:0] CAP_HI    = 8'(RD_LAT + 6);
    localparam logic [7:0] LOAD_LAST = 8'(RD_LAT + 7);
    localparam logic [7:0] EXEC_LAST = 8'(FPU_LATENCY);

    state_t                state, state_d;
    logic [7:0]            cnt, cnt_d;
    logic [SW-1:0]         ptr, ptr_d, next_ptr;
    logic [7:0]            cmd_q, cmd_d;
    logic [63:0]           ab_q, ab_d;
    logic [31:0]           res_q, res_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [7:0]            dout_d;
    logic                  wen_d, start_d, busy_d, done_d;

    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [SW-1:0] s,
                                                        input logic [3:0] off);
        return (ADDR_WIDTH'(s) << 4) | ADDR_WIDTH'(off);
    endfunction

    assign next_ptr = (ptr == SW'(NUM_SLOTS - 1)) ? '0 : ptr + SW'(1);

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 8'd1;
        ptr_d   = ptr;
        cmd_d   = cmd_q;
        ab_d    = ab_q;
        res_d   = res_q;
        op_d    = op_q;

        case (state)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (enable) state_d = S_POLL;
            end
            S_POLL: begin
                if (cnt == CMD_CAP) cmd_d = data_in;
                if (cnt == POLL_LAST) begin
                    cnt_d = 8'd0;
                    if (cmd_q[7]) begin
                        if (cmd_q[6:2] == 5'd0) begin
                            state_d = S_LOAD;
                            op_d    = cmd_q[1:0];
                        end else begin
                            state_d = S_WERR;
                        end
                    end else begin
                        ptr_d   = next_ptr;
                        state_d = enable ? S_POLL : S_IDLE;
                    end
                end
            end
            S_LOAD: begin
                // A then B arrive MSB-first, so one 64-bit shift lands both big-endian
                if (cnt >= CAP_LO && cnt <= CAP_HI) ab_d = {ab_q[55:0], data_in};
                if (cnt == LOAD_LAST) begin
                    state_d = S_EXEC;
                    cnt_d   = 8'd0;
                end
            end
            S_EXEC: begin
                if (cnt == EXEC_LAST) begin
                    res_d   = fpu_s;
                    state_d = S_WRITE;
                    cnt_d   = 8'd0;
                end
            end
            S_WRITE: begin
                if (cnt == 8'd5) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end
            end
            S_WERR: begin
                if (cnt == 8'd1) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end
            end
            S_DONE: begin
                ptr_d   = next_ptr;
                cnt_d   = 8'd0;
                state_d = enable ? S_POLL : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Outputs are registered: derive them from where the FSM will be next cycle
        addr_d  = addr;
        dout_d  = data_out;
        wen_d   = 1'b0;
        start_d = (state_d == S_EXEC) && (state != S_EXEC);
        busy_d  = (state_d == S_LOAD) || (state_d == S_EXEC) ||
                  (state_d == S_WRITE) || (state_d == S_WERR);
        done_d  = (state_d == S_DONE);

        case (state_d)
            S_POLL: addr_d = slot_addr(ptr_d, 4'd0);
            S_LOAD: begin
                if (cnt_d < 8'd8) addr_d = slot_addr(ptr_d, 4'(cnt_d) + 4'd1);
            end
            S_WRITE: begin
                wen_d = 1'b1;
                case (cnt_d[2:0])
                    3'd0: begin addr_d = slot_addr(ptr_d, 4'd10); dout_d = res_d[31:24]; end
                    3'd1: begin addr_d = slot_addr(ptr_d, 4'd11); dout_d = res_d[23:16]; end
                    3'd2: begin addr_d = slot_addr(ptr_d, 4'd12); dout_d = res_d[15:8];  end
                    3'd3: begin addr_d = slot_addr(ptr_d, 4'd13); dout_d = res_d[7:0];   end
                    3'd4: begin addr_d = slot_addr(ptr_d, 4'd9);  dout_d = {6'b100000, op_q}; end
                    default: begin addr_d = slot_addr(ptr_d, 4'd0); dout_d = 8'h00; end
                endcase
            end
            S_WERR: begin
                wen_d = 1'b1;
                if (cnt_d == 8'd0) begin
                    addr_d = slot_addr(ptr_d, 4'd9);
                    dout_d = 8'hC0;
                end else begin
                    addr_d = slot_addr(ptr_d, 4'd0);
                    dout_d = 8'h00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            ptr       <= '0;
            cmd_q     <= 8'd0;
            ab_q      <= 64'd0;
            res_q     <= 32'd0;
            op_q      <= 2'd0;
            addr      <= '0;
            data_out  <= 8'd0;
            wen       <= 1'b0;
            fpu_start <= 1'b0;
            busy      <= 1'b0;
            cmd_done  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ptr       <= ptr_d;
            cmd_q     <= cmd_d;
            ab_q      <= ab_d;
            res_q     <= res_d;
            op_q      <= op_d;
            addr      <= addr_d;
            data_out  <= dout_d;
            wen       <= wen_d;
            fpu_start <= start_d;
            busy      <= busy_d;
            cmd_done  <= done_d;
        end
    end

    assign fpu_op   = op_q;
    assign fpu_a    = ab_q[63:32];
    assign fpu_b    = ab_q[31:0];
    assign cmd_slot = ptr;

endmodule
